multicycle_control: RTL and testbench

// - Multi-cycle control FSM for the simple CPU; successor to the single-cycle opcode decoder.
// - Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB; shares one ALU and one memory port.
// - Waits on the memory handshake, traps on illegal opcode or bus timeout, counts retired instructions.

---
 rtl/cpu_ctrl_pkg.sv | 54 +++++
 rtl/multicycle_control_mem_wait_timer.sv | 39 +++
 rtl/multicycle_control.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control path.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_LOAD   = 6'b001110;
  localparam logic [5:0] OP_STORE  = 6'b100110;
  localparam logic [5:0] OP_ADDI   = 6'b001111;
  localparam logic [5:0] OP_BRANCH = 6'b001100;
  localparam logic [5:0] OP_JUMP   = 6'b000100;

  localparam logic [5:0] ALU_ADD = 6'b000010;
  localparam logic [5:0] ALU_SUB = 6'b000110;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    ALUB_RT      = 2'b00,
    ALUB_FOUR    = 2'b01,
    ALUB_IMM     = 2'b10,
    ALUB_IMM_SH2 = 2'b11
  } alu_b_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_BUS     = 2'b10
  } trap_cause_e;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR,
    MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP, TRAP
  } state_e;

  // Datapath control word driven by the sequencer each cycle.
  typedef struct packed {
    logic    pc_write;
    logic    pc_write_cond;
    pc_src_e pc_source;
    logic    iord;
    logic    mem_read;
    logic    mem_write;
    logic    ir_write;
    logic    reg_dst;
    logic    mem_to_reg;
    logic    reg_write;
    logic    alu_src_a;
    alu_b_e  alu_src_b;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts cycles spent waiting for mem_ready; expired_o flags the last allowed wait cycle.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          expired_q, expired_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i) begin
      cnt_d = cnt_q + TW'(1);
    end
    expired_d = (cnt_d == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      expired_q <= (TIMEOUT == 1);
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared ALU and memory port.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPW         = 6,
  parameter int unsigned ALUOPW      = 6,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned RETW        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic              mem_ready,
  input  logic              zero,
  output logic              pc_write,
  output logic              pc_write_cond,
  output logic [1:0]        pc_source,
  output logic              iord,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [ALUOPW-1:0] aluop,
  output logic              instr_done,
  output logic              trap,
  output logic [1:0]        trap_cause,
  output logic [RETW-1:0]   retired
);

  state_e            state_q, state_d;
  logic              trap_q, trap_d;
  trap_cause_e       cause_q, cause_d;
  logic [RETW-1:0]   retired_q, retired_d;
  ctrl_t             ctrl_c;
  logic [ALUOPW-1:0] aluop_c;
  logic              done_c;
  logic              mem_state_c;
  logic              expired;
  logic [OPW-1:0]    opcode;
  logic              unused_inputs;

  assign opcode = instruction[31:32-OPW];
  // PC-condition gating with zero happens in the datapath, not here.
  assign unused_inputs = ^{instruction[31-OPW:ALUOPW], zero};

  mem_wait_timer #(
    .TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_d != state_q),
    .count_i  (mem_state_c && !mem_ready),
    .expired_o(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      trap_q    <= 1'b0;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    trap_d      = trap_q;
    cause_d     = cause_q;
    ctrl_c      = '0;
    aluop_c     = '0;
    done_c      = 1'b0;
    mem_state_c = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_state_c      = 1'b1;
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_b = ALUB_FOUR;
        aluop_c          = ALUOPW'(ALU_ADD);
        if (mem_ready) begin
          ctrl_c.ir_write  = 1'b1;
          ctrl_c.pc_write  = 1'b1;
          ctrl_c.pc_source = PCSRC_ALU;
          state_d          = DECODE;
        end
      end
      DECODE: begin
        ctrl_c.alu_src_b = ALUB_IMM_SH2;
        aluop_c          = ALUOPW'(ALU_ADD);
        case (opcode)
          OPW'(OP_RTYPE):  state_d = EXEC_R;
          OPW'(OP_LOAD):   state_d = MEM_ADDR;
          OPW'(OP_STORE):  state_d = MEM_ADDR;
          OPW'(OP_ADDI):   state_d = EXEC_I;
          OPW'(OP_BRANCH): state_d = BRANCH;
          OPW'(OP_JUMP):   state_d = JUMP;
          default: begin
            state_d = TRAP;
            trap_d  = 1'b1;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      EXEC_R: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = ALUB_RT;
        aluop_c          = instruction[ALUOPW-1:0];
        state_d          = WB_R;
      end
      WB_R: begin
        ctrl_c.reg_dst   = 1'b1;
        ctrl_c.reg_write = 1'b1;
        done_c           = 1'b1;
        state_d          = FETCH;
      end
      EXEC_I, MEM_ADDR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = ALUB_IMM;
        aluop_c          = ALUOPW'(ALU_ADD);
        if (state_q == EXEC_I) begin
          state_d = WB_I;
        end else if (opcode == OPW'(OP_LOAD)) begin
          state_d = MEM_RD;
        end else begin
          state_d = MEM_WR;
        end
      end
      WB_I: begin
        ctrl_c.reg_write = 1'b1;
        done_c           = 1'b1;
        state_d          = FETCH;
      end
      MEM_RD: begin
        mem_state_c     = 1'b1;
        ctrl_c.iord     = 1'b1;
        ctrl_c.mem_read = 1'b1;
        if (mem_ready) state_d = WB_MEM;
      end
      WB_MEM: begin
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.reg_write  = 1'b1;
        done_c            = 1'b1;
        state_d           = FETCH;
      end
      MEM_WR: begin
        mem_state_c      = 1'b1;
        ctrl_c.iord      = 1'b1;
        ctrl_c.mem_write = 1'b1;
        if (mem_ready) begin
          done_c  = 1'b1;
          state_d = FETCH;
        end
      end
      BRANCH: begin
        ctrl_c.alu_src_a     = 1'b1;
        ctrl_c.alu_src_b     = ALUB_RT;
        aluop_c              = ALUOPW'(ALU_SUB);
        ctrl_c.pc_write_cond = 1'b1;
        ctrl_c.pc_source     = PCSRC_ALUOUT;
        done_c               = 1'b1;
        state_d              = FETCH;
      end
      JUMP: begin
        ctrl_c.pc_write  = 1'b1;
        ctrl_c.pc_source = PCSRC_JUMP;
        done_c           = 1'b1;
        state_d          = FETCH;
      end
      TRAP: state_d = TRAP;
      default: state_d = IDLE;
    endcase

    // A ready on the final allowed wait cycle still completes the access.
    if (mem_state_c && !mem_ready && expired) begin
      state_d = TRAP;
      trap_d  = 1'b1;
      cause_d = CAUSE_BUS;
    end

    // Reset aborts the instruction in flight without any write strobe.
    if (rst) begin
      ctrl_c  = '0;
      aluop_c = '0;
      done_c  = 1'b0;
    end

    retired_d = done_c ? retired_q + RETW'(1) : retired_q;
  end

  assign pc_write      = ctrl_c.pc_write;
  assign pc_write_cond = ctrl_c.pc_write_cond;
  assign pc_source     = ctrl_c.pc_source;
  assign iord          = ctrl_c.iord;
  assign mem_read      = ctrl_c.mem_read;
  assign mem_write     = ctrl_c.mem_write;
  assign ir_write      = ctrl_c.ir_write;
  assign reg_dst       = ctrl_c.reg_dst;
  assign mem_to_reg    = ctrl_c.mem_to_reg;
  assign reg_write     = ctrl_c.reg_write;
  assign alu_src_a     = ctrl_c.alu_src_a;
  assign alu_src_b     = ctrl_c.alu_src_b;
  assign aluop         = aluop_c;
  assign instr_done    = done_c;
  assign trap          = trap_q;
  assign trap_cause    = cause_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against a per-instruction phase-plan reference model.
module tb_multicycle_control;

  localparam int unsigned TO = 15;
  localparam int unsigned RW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction = 32'd0;
  logic        mem_ready = 1'b0;
  logic        zero = 1'b0;
  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, trap;
  logic [1:0]  pc_source, alu_src_b, trap_cause;
  logic [5:0]  aluop;
  logic [RW-1:0] retired;

  always #5 clk = ~clk;

  multicycle_control #(
    .OPW(6), .ALUOPW(6), .MEM_TIMEOUT(TO), .RETW(RW)
  ) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .mem_ready(mem_ready), .zero(zero),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .aluop(aluop), .instr_done(instr_done), .trap(trap),
    .trap_cause(trap_cause), .retired(retired)
  );

  typedef enum int {
    PH_IDLE, PH_FETCH, PH_DECODE, PH_EXEC_R, PH_ADDR_I, PH_WB_R, PH_WB_I,
    PH_MEM_RD, PH_MEM_WR, PH_WB_MEM, PH_BRANCH, PH_JUMP, PH_TRAP
  } phase_e;

  int         total = 0;
  int         bad = 0;
  int         m_ret = 0;
  logic       m_trap = 1'b0;
  logic [1:0] m_cause = 2'b00;

  logic [20:0] dut_vec;
  assign dut_vec = {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
                    reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, aluop, instr_done};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b001110, 6'b100110, 6'b001111, 6'b001100, 6'b000100};
  endfunction

  // Expected control word for one cycle of a phase.
  function automatic logic [20:0] model_vec(input phase_e ph, input logic rdy, input logic [5:0] funct);
    logic pcw, pcc, io, mr, mw, irw, rd, m2r, rw, sa, dn;
    logic [1:0] ps, sb;
    logic [5:0] op;
    {pcw, pcc, io, mr, mw, irw, rd, m2r, rw, sa, dn} = '0;
    ps = 2'b00; sb = 2'b00; op = 6'b000000;
    case (ph)
      PH_FETCH:  begin mr = 1; sb = 2'b01; op = 6'b000010; irw = rdy; pcw = rdy; end
      PH_DECODE: begin sb = 2'b11; op = 6'b000010; end
      PH_EXEC_R: begin sa = 1; sb = 2'b00; op = funct; end
      PH_ADDR_I: begin sa = 1; sb = 2'b10; op = 6'b000010; end
      PH_WB_R:   begin rd = 1; rw = 1; dn = 1; end
      PH_WB_I:   begin rw = 1; dn = 1; end
      PH_MEM_RD: begin io = 1; mr = 1; end
      PH_MEM_WR: begin io = 1; mw = 1; dn = rdy; end
      PH_WB_MEM: begin m2r = 1; rw = 1; dn = 1; end
      PH_BRANCH: begin sa = 1; op = 6'b000110; pcc = 1; ps = 2'b01; dn = 1; end
      PH_JUMP:   begin pcw = 1; ps = 2'b10; dn = 1; end
      default:   ;
    endcase
    return {pcw, pcc, ps, io, mr, mw, irw, rd, m2r, rw, sa, sb, op, dn};
  endfunction

  task automatic cyc(input phase_e ph, input logic rdy, input logic [31:0] ins, input logic zr,
                     input logic rs, input string tag, output bit dn);
    logic [20:0] e;
    @(negedge clk);
    rst = rs; instruction = ins; mem_ready = rdy; zero = zr;
    #1;
    e = rs ? 21'd0 : model_vec(ph, rdy, ins[5:0]);
    check({tag, "/ctrl"}, 32'(dut_vec), 32'(e));
    check({tag, "/trap"}, 32'(trap), 32'(m_trap));
    check({tag, "/cause"}, 32'(trap_cause), 32'(m_cause));
    check({tag, "/retired"}, 32'(retired), 32'(m_ret));
    dn = instr_done;
    if (rs) begin
      m_ret = 0; m_trap = 1'b0; m_cause = 2'b00;
    end else if (e[0]) begin
      m_ret = (m_ret + 1) % (1 << RW);
    end
  endtask

  task automatic do_reset(input string tag);
    bit dn;
    cyc(PH_IDLE, 1'b1, 32'd0, 1'b0, 1'b1, tag, dn);
    cyc(PH_IDLE, 1'b0, 32'd0, 1'b1, 1'b1, tag, dn);
    cyc(PH_IDLE, 1'($urandom_range(0, 1)), 32'd0, 1'b0, 1'b0, {tag, "/idle"}, dn);
  endtask

  // Builds the phase plan from the opcode and plays it with the given wait counts.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic zr,
                           input string tag, output bit trapped);
    phase_e plan[$];
    logic [5:0] op;
    int lat, cycles, done_at, w;
    bit mem_op, rdy, dn;
    op = ins[31:26];
    trapped = 0; cycles = 0; done_at = -1; mem_op = 0; lat = 0;
    plan = '{PH_FETCH, PH_DECODE};
    case (op)
      6'b000000: begin plan.push_back(PH_EXEC_R); plan.push_back(PH_WB_R); lat = 4; end
      6'b001111: begin plan.push_back(PH_ADDR_I); plan.push_back(PH_WB_I); lat = 4; end
      6'b001110: begin plan.push_back(PH_ADDR_I); plan.push_back(PH_MEM_RD);
                       plan.push_back(PH_WB_MEM); lat = 5; mem_op = 1; end
      6'b100110: begin plan.push_back(PH_ADDR_I); plan.push_back(PH_MEM_WR); lat = 4; mem_op = 1; end
      6'b001100: begin plan.push_back(PH_BRANCH); lat = 3; end
      6'b000100: begin plan.push_back(PH_JUMP); lat = 3; end
      default:   lat = 0;
    endcase
    for (int i = 0; i < plan.size() && !trapped; i++) begin
      if (plan[i] == PH_FETCH || plan[i] == PH_MEM_RD || plan[i] == PH_MEM_WR) begin
        w = (plan[i] == PH_FETCH) ? fw : mw;
        for (int k = 0; k < int'(TO); k++) begin
          rdy = (k >= w);
          cyc(plan[i], rdy, ins, zr, 1'b0, tag, dn);
          cycles++;
          if (dn && done_at < 0) done_at = cycles;
          if (rdy) break;
          if (k == int'(TO) - 1) begin trapped = 1; m_trap = 1'b1; m_cause = 2'b10; end
        end
      end else begin
        cyc(plan[i], 1'($urandom_range(0, 1)), ins, zr, 1'b0, tag, dn);
        cycles++;
        if (dn && done_at < 0) done_at = cycles;
      end
    end
    if (!trapped) begin
      if (lat == 0) begin
        trapped = 1; m_trap = 1'b1; m_cause = 2'b01;
      end else begin
        check({tag, "/latency"}, 32'(done_at), 32'(lat + fw + (mem_op ? mw : 0)));
      end
    end
  endtask

  task automatic after_trap(input string tag);
    bit dn;
    for (int i = 0; i < 4; i++)
      cyc(PH_TRAP, 1'($urandom_range(0, 1)), 32'($urandom()), 1'($urandom_range(0, 1)),
          1'b0, tag, dn);
    do_reset({tag, "/rst"});
  endtask

  initial begin
    bit tr, dn;
    logic [31:0] r, ins;
    logic [5:0] op;
    int kind, fw, mw;

    do_reset("reset");
    run_instr({6'b000000, 20'h12345, 6'b100000}, 0, 0, 1'b0, "rtype", tr);
    run_instr({6'b001110, 26'h0000123}, 0, 3, 1'b0, "load_wait3", tr);
    run_instr({6'b001100, 26'h0000040}, 0, 0, 1'b1, "branch_z1", tr);
    run_instr({6'b001100, 26'h0000040}, 0, 0, 1'b0, "branch_z0", tr);
    run_instr({6'b100110, 26'h0000008}, 1, 2, 1'b0, "store", tr);
    run_instr({6'b001111, 26'h0000fff}, 0, 0, 1'b0, "addi", tr);
    run_instr({6'b000100, 26'h0000100}, 0, 0, 1'b0, "jump", tr);
    run_instr({6'b001110, 26'h0000010}, int'(TO) - 1, int'(TO) - 1, 1'b0, "ready_last", tr);

    ins = {6'b001110, 26'h0000020};
    cyc(PH_FETCH, 1'b1, ins, 1'b0, 1'b0, "midload", dn);
    cyc(PH_DECODE, 1'b0, ins, 1'b0, 1'b0, "midload", dn);
    cyc(PH_ADDR_I, 1'b0, ins, 1'b0, 1'b0, "midload", dn);
    cyc(PH_MEM_RD, 1'b0, ins, 1'b0, 1'b0, "midload", dn);
    cyc(PH_MEM_RD, 1'b0, ins, 1'b0, 1'b0, "midload", dn);
    do_reset("midload_rst");

    for (int i = 0; i < 16; i++) run_instr({6'b000100, 26'h0}, 0, 0, 1'b0, "jump16", tr);
    do_reset("retired_wrap");

    run_instr({6'b111111, 26'h3ffffff}, 0, 0, 1'b0, "illegal", tr);
    after_trap("illegal_trap");
    run_instr({6'b000100, 26'h0}, 40, 0, 1'b0, "fetch_timeout", tr);
    after_trap("fetch_timeout_trap");
    run_instr({6'b100110, 26'h0}, 0, int'(TO), 1'b0, "store_timeout", tr);
    after_trap("store_timeout_trap");

    for (int n = 0; n < 150; n++) begin
      r = $urandom();
      kind = $urandom_range(0, 19);
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      case (kind)
        0, 1, 2:    op = 6'b000000;
        3, 4, 5:    op = 6'b001110;
        6, 7, 8:    op = 6'b100110;
        9, 10, 11:  op = 6'b001111;
        12, 13, 14: op = 6'b001100;
        15, 16:     op = 6'b000100;
        17: begin op = 6'b000100; fw = $urandom_range(13, 16); end
        18: begin
          op = 6'($urandom());
          while (is_legal(op)) op = 6'($urandom());
        end
        default: begin
          op = r[31] ? 6'b001110 : 6'b100110;
          mw = $urandom_range(13, 16);
        end
      endcase
      ins = {op, r[25:0]};
      run_instr(ins, fw, mw, 1'($urandom_range(0, 1)), "random", tr);
      if (tr) after_trap("random_trap");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
